e_hilo: RTL
===========

# e_hilo

Multiply/divide unit with HI/LO registers for the EX stage of the five-stage MIPS pipeline. It consumes the 5-bit `HILOOp` that the decoder produces for each instruction, together with the forwarded EX operands, and executes mult/multu/div/divu as multi-cycle operations. It also executes mthi/mtlo writes and mfhi/mflo reads. `Start` and `Busy` go back to the hazard unit, which stalls any `isHILO` instruction in D while either is high.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1..15.

Ports:
- `clk`  in  1: clock. Everything is rising-edge.
- `reset`  in  1: asynchronous, active-high. Clears all state.
- `Req`  in  1: exception/interrupt request in the current cycle. Suppresses a new start or an mt write this cycle.
- `HILOOp`  in  5: operation code. 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO. Any other value is treated as NONE.
- `A`  in  32: rs operand (forwarded).
- `B`  in  32: rt operand (forwarded).
- `Start`  out  1: combinational. High when `HILOOp` is 1..4, `Req`=0 and `Busy`=0.
- `Busy`  out  1: registered. High while a mul/div is in flight.
- `Out`  out  32: combinational. HI for MFHI, LO for MFLO, 0 otherwise.
- `HI`  out  32: architectural HI register.
- `LO`  out  32: architectural LO register.

## Operation
- **State**
  - `HI`, `LO`.
  - Result buffers `tHI`, `tLO`.
  - 4-bit down-counter `cnt`.
  - `Busy` flag.
  - `dz` flag: pending divide-by-zero.
- **Start** (Start=1 at a clock edge)
  - Compute the result from the current `A`, `B` into `tHI`/`tLO`.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`.
  - Set `Busy`=1.
  - Set `dz` = (op is DIV/DIVU and `B`==0).
- **MULT**: {tHI,tLO} = signed 64-bit product of A×B.
- **MULTU**: {tHI,tLO} = unsigned 64-bit product.
- **DIV**: tLO = signed quotient truncated toward zero; tHI = remainder, carrying the sign of the dividend.
- **DIVU**: unsigned quotient and remainder.
- **Divide by zero**: at completion, HI and LO keep their previous values. No exception is raised.
- **Busy countdown**: each edge with Busy=1 decrements `cnt`. At the edge where `cnt`==1:
  - Busy←0.
  - HI←tHI and LO←tLO, unless `dz` is set.
- **MTHI / MTLO**: at the edge, HI←A or LO←A, only when Req=0 and Busy=0. An mt op while Busy=1 is ignored; the hazard unit prevents this case.
- **Mul/div op while Busy=1**: ignored, with no restart and no operand capture.
- **Req=1**:
  - Blocks a start or an mt write in that cycle.
  - Does NOT abort an operation already in flight; it completes and commits.
- **MF reads**: `Out` always reflects the committed HI/LO. It never shows in-flight results.
- **Reset**:
  - HI, LO, tHI, tLO = 0.
  - cnt=0, Busy=0, dz=0.
  - Start and Out are therefore 0 under reset.
  - Reset asserted mid-operation discards the operation entirely; HI/LO stay 0.

## Timing
- **Cycle 0**: HILOOp=1..4 and Start=1 (combinational).
- **Cycles 1..N**: Busy=1, where N = MULT_CYCLES or DIV_CYCLES.
- **Edge ending cycle N**: Busy falls and HI/LO update. The new value is visible on HI/LO/Out in cycle N+1.
- **Back-to-back**: a second mul/div may start in cycle N+1 (earliest). No overlap is possible.
- **mt write**: in cycle k, visible in cycle k+1. An MF in the cycle immediately after an MT returns the new value.
- **Simultaneous commit and mt**: cannot occur, because an mt is ignored while Busy=1.

## Test plan
- **mult**: MULT A=0xFFFFFFFD (−3), B=5 -> Start=1 in cycle 0; Busy=1 in cycles 1–5 exactly; cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- **multu**: MULTU A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- **div / divu**:
  - DIV A=0xFFFFFFF9 (−7), B=2 -> Busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- **Divide by zero**: MTHI A=0x1234, then MTLO A=0x5678, then DIV B=0 -> Busy for 10 cycles; afterwards HI=0x1234, LO=0x5678. MFHI gives Out=0x1234.
- **Req and busy blocking**:
  - MULT with Req=1 -> Start=0, Busy never rises, HI/LO unchanged.
  - MTHI with Req=1 -> HI unchanged.
  - Req=1 during busy cycle 3 of a MULT -> the result still commits in cycle 6.
  - DIV issued in busy cycle 2 -> ignored; the first op's result commits.
- **Reset mid-operation**: assert reset in busy cycle 4 of a DIV -> Busy=0 and HI=LO=0 immediately (asynchronous); after release, no late commit occurs and a new MULT starts normally.

Source files
------------

// File: rtl/e_hilo.sv
// EX-stage multiply/divide unit with architectural HI/LO registers.
// A mul/div result is held in tHI/tLO and committed to HI/LO when the countdown ends.
module e_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [4:0]  HILOOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] Out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [4:0] {
        OP_NONE  = 5'd0,
        OP_MULT  = 5'd1,
        OP_MULTU = 5'd2,
        OP_DIV   = 5'd3,
        OP_DIVU  = 5'd4,
        OP_MFHI  = 5'd5,
        OP_MFLO  = 5'd6,
        OP_MTHI  = 5'd7,
        OP_MTLO  = 5'd8
    } hilo_op_e;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] thi_q, thi_d, tlo_q, tlo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        dz_q, dz_d;

    logic        is_md, is_div;
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_safe, b_mag_safe;
    logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic [31:0] res_hi, res_lo;

    always_comb begin
        is_md  = (HILOOp == OP_MULT) || (HILOOp == OP_MULTU) ||
                 (HILOOp == OP_DIV)  || (HILOOp == OP_DIVU);
        is_div = (HILOOp == OP_DIV)  || (HILOOp == OP_DIVU);
        Start  = is_md && !Req && !busy_q && !reset;
    end

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    always_comb begin
        prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u = {32'd0, A} * {32'd0, B};
    end

    // Divisor forced to 1 on zero: the result is discarded by the dz flag anyway.
    always_comb begin
        b_safe     = (B == 32'd0) ? 32'd1 : B;
        a_mag      = A[31] ? (32'd0 - A) : A;
        b_mag      = B[31] ? (32'd0 - B) : B;
        b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / b_mag_safe;
        r_mag      = a_mag % b_mag_safe;
        q_s        = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
        r_s        = A[31] ? (32'd0 - r_mag) : r_mag;
        q_u        = A / b_safe;
        r_u        = A % b_safe;
    end

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (HILOOp)
            OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            OP_DIV:   begin res_hi = r_s;           res_lo = q_s;          end
            OP_DIVU:  begin res_hi = r_u;           res_lo = q_u;          end
            default:  begin res_hi = '0;            res_lo = '0;           end
        endcase
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        thi_d  = thi_q;
        tlo_d  = tlo_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        dz_d   = dz_q;
        if (busy_q) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                busy_d = 1'b0;
                if (!dz_q) begin
                    hi_d = thi_q;
                    lo_d = tlo_q;
                end
            end
        end else if (Start) begin
            thi_d  = res_hi;
            tlo_d  = res_lo;
            cnt_d  = is_div ? DIV_CNT : MULT_CNT;
            busy_d = 1'b1;
            dz_d   = is_div && (B == 32'd0);
        end else if (!Req) begin
            if (HILOOp == OP_MTHI) begin
                hi_d = A;
            end else if (HILOOp == OP_MTLO) begin
                lo_d = A;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            thi_q  <= '0;
            tlo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            thi_q  <= thi_d;
            tlo_q  <= tlo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            dz_q   <= dz_d;
        end
    end

    always_comb begin
        Busy = busy_q;
        HI   = hi_q;
        LO   = lo_q;
        case (HILOOp)
            OP_MFHI: Out = hi_q;
            OP_MFLO: Out = lo_q;
            default: Out = '0;
        endcase
    end

endmodule
